// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants and types for the Booth multiplier control unit
//
// Contents:
//   N_DEFAULT  default operand width and Booth iteration count
//   state_t    controller state encoding (3 bits): IDLE, LOAD, TEST, SHIFT, DONE
//   BOOTH_SUB  {q0,q_1} pair that selects A <= A - M
//   BOOTH_ADD  {q0,q_1} pair that selects A <= A + M
package booth_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_cnt.sv
// rtl/booth_cnt.sv - loadable down-counter tracking remaining Booth iterations
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset, clears the count
//   load       in   load the count from d
//   dec        in   decrement the count (load has priority)
//   d          in   W-bit load value
//   zero_next  out  count is 1, so the pending decrement reaches zero
module booth_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic         zero_next
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= d;
    end else if (dec && (r_cnt != '0)) begin
      // Guard keeps the counter from wrapping if dec is ever seen at zero.
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero_next = (r_cnt == W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - control FSM sequencing the A/Q/M registers of a radix-2 Booth multiplier
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   inicio     in   start request, sampled only in IDLE and DONE
//   q0, q_1    in   Q register bit 0 and extra bit q-1
//   CargaM     out  load multiplicand M
//   CargaQ     out  load Q and clear q-1
//   ResetA     out  clear accumulator A
//   CargaA     out  load A with adder result
//   resta      out  adder op, 1 = A-M, 0 = A+M (valid with CargaA)
//   DesplazaA  out  arithmetic shift right of A
//   DesplazaQ  out  shift right of Q
//   fin        out  product valid in {A,Q}
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inicio,
  input  logic q0,
  input  logic q_1,
  output logic CargaM,
  output logic CargaQ,
  output logic ResetA,
  output logic CargaA,
  output logic resta,
  output logic DesplazaA,
  output logic DesplazaQ,
  output logic fin
);

  localparam int CNT_W = $clog2(N + 1);

  state_t r_state;
  state_t w_next_state;
  logic   w_cnt_load;
  logic   w_cnt_dec;
  logic   w_last_iter;

  booth_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (w_cnt_load),
    .dec       (w_cnt_dec),
    .d         (CNT_W'(N)),
    .zero_next (w_last_iter)
  );

  assign w_cnt_load = (r_state == LOAD);
  assign w_cnt_dec  = (r_state == SHIFT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = inicio ? LOAD : IDLE;
      LOAD:    w_next_state = TEST;
      TEST:    w_next_state = SHIFT;
      SHIFT:   w_next_state = w_last_iter ? DONE : TEST;
      DONE:    w_next_state = inicio ? DONE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    CargaM    = 1'b0;
    CargaQ    = 1'b0;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    resta     = 1'b0;
    DesplazaA = 1'b0;
    DesplazaQ = 1'b0;
    fin       = 1'b0;
    case (r_state)
      LOAD: begin
        CargaM = 1'b1;
        CargaQ = 1'b1;
        ResetA = 1'b1;
      end
      TEST: begin
        // 00 and 11 are runs of equal bits: no add/subtract this iteration.
        case ({q0, q_1})
          BOOTH_SUB: begin
            CargaA = 1'b1;
            resta  = 1'b1;
          end
          BOOTH_ADD: CargaA = 1'b1;
          default: ;
        endcase
      end
      SHIFT: begin
        DesplazaA = 1'b1;
        DesplazaQ = 1'b1;
      end
      DONE:    fin = 1'b1;
      default: ;
    endcase
  end

endmodule
